// File: rtl/dvi_timing_gen_if.sv
// DVI raster timing bundle: config-done input plus sync/DE/coordinate outputs.
interface dvi_timing_gen_if #(
    parameter int unsigned CNT_W = 10
) ();
    logic             Cfg_done;
    logic             Hsync;
    logic             Vsync;
    logic             De;
    logic             Req;
    logic [CNT_W-1:0] Pix_x;
    logic [CNT_W-1:0] Pix_y;
    logic             Line_start;
    logic             Frame_start;
    logic             Running;

    // Timing generator side
    modport master (
        input  Cfg_done,
        output Hsync, Vsync, De, Req, Pix_x, Pix_y, Line_start, Frame_start, Running
    );

    // Config block / pixel sink side
    modport slave (
        output Cfg_done,
        input  Hsync, Vsync, De, Req, Pix_x, Pix_y, Line_start, Frame_start, Running
    );
endinterface

// File: rtl/dvi_timing_gen.sv
// Raster timing generator: waits for transmitter config, settles, then runs
// continuous sync / data-enable / coordinate timing with a one-cycle-early Req.
module dvi_timing_gen #(
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned H_FP          = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BP          = 48,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned V_FP          = 10,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_BP          = 33,
    parameter logic        HS_POL        = 1'b0,
    parameter logic        VS_POL        = 1'b0,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned CNT_W         = 10
) (
    input  logic               Clk,
    input  logic               Reset_n,
    dvi_timing_gen_if.master   vid
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int unsigned S_W      = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        WAIT_CFG = 2'd0,
        SETTLE   = 2'd1,
        RUN      = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [S_W-1:0]     s_cnt_q, s_cnt_d;
    logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;

    logic               de_q, req_q, line_start_q, frame_start_q, running_q;
    logic               hsync_q, vsync_q;
    logic [CNT_W-1:0]   pix_x_q, pix_y_q;

    logic               run_q_c, run_d_c;
    logic               act_q_c, act_d_c;
    logic               hs_act_c, vs_act_c;

    // State and raster counters
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= WAIT_CFG;
            s_cnt_q <= '0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Next state; counters are zero everywhere except while staying in RUN
    always_comb begin
        state_d = state_q;
        s_cnt_d = '0;
        h_cnt_d = '0;
        v_cnt_d = '0;
        case (state_q)
            WAIT_CFG: begin
                if (vid.Cfg_done) state_d = SETTLE;
            end
            SETTLE: begin
                if (!vid.Cfg_done) begin
                    state_d = WAIT_CFG;
                end else if (s_cnt_q == S_W'(SETTLE_CYCLES - 1)) begin
                    state_d = RUN;
                end else begin
                    s_cnt_d = s_cnt_q + S_W'(1);
                end
            end
            RUN: begin
                if (!vid.Cfg_done) begin
                    state_d = WAIT_CFG;
                end else if (h_cnt_q == CNT_W'(H_TOTAL - 1)) begin
                    h_cnt_d = '0;
                    v_cnt_d = (v_cnt_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + CNT_W'(1);
                end else begin
                    h_cnt_d = h_cnt_q + CNT_W'(1);
                    v_cnt_d = v_cnt_q;
                end
            end
            default: state_d = WAIT_CFG;
        endcase
    end

    // Region decodes on the current and the next counter state
    always_comb begin
        run_q_c  = (state_q == RUN);
        run_d_c  = (state_d == RUN);
        act_q_c  = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));
        act_d_c  = (h_cnt_d < CNT_W'(H_ACTIVE)) && (v_cnt_d < CNT_W'(V_ACTIVE));
        hs_act_c = (h_cnt_q >= CNT_W'(HS_START)) && (h_cnt_q < CNT_W'(HS_END));
        vs_act_c = (v_cnt_q >= CNT_W'(VS_START)) && (v_cnt_q < CNT_W'(VS_END));
    end

    // Registered outputs; Req uses the next-state decode so it leads De by one cycle
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            de_q          <= 1'b0;
            req_q         <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
        end else begin
            req_q         <= run_d_c && act_d_c;
            running_q     <= run_d_c;
            de_q          <= run_q_c && act_q_c;
            line_start_q  <= run_q_c && act_q_c && (h_cnt_q == '0);
            frame_start_q <= run_q_c && (h_cnt_q == '0) && (v_cnt_q == '0);
            hsync_q       <= (run_q_c && hs_act_c) ? HS_POL : ~HS_POL;
            vsync_q       <= (run_q_c && vs_act_c) ? VS_POL : ~VS_POL;
            if (!run_q_c) begin
                pix_x_q <= '0;
                pix_y_q <= '0;
            end else if (act_q_c) begin
                pix_x_q <= h_cnt_q;
                pix_y_q <= v_cnt_q;
            end
        end
    end

    assign vid.De          = de_q;
    assign vid.Req         = req_q;
    assign vid.Line_start  = line_start_q;
    assign vid.Frame_start = frame_start_q;
    assign vid.Running     = running_q;
    assign vid.Hsync       = hsync_q;
    assign vid.Vsync       = vsync_q;
    assign vid.Pix_x       = pix_x_q;
    assign vid.Pix_y       = pix_y_q;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Directed bench for dvi_timing_gen using a reduced raster so two full frames fit.
module tb_dvi_timing_gen;

    localparam int unsigned HA = 40, HFP = 8, HS = 12, HBP = 6;
    localparam int unsigned VA = 12, VFP = 3, VS = 2,  VBP = 4;
    localparam int unsigned SETTLE = 1024;
    localparam int unsigned CW = 10;
    localparam int unsigned HT = HA + HFP + HS + HBP;   // 66
    localparam int unsigned VT = VA + VFP + VS + VBP;   // 21
    localparam int unsigned FRAME = HT * VT;            // 1386

    logic Clk = 1'b0;
    logic Reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    dvi_timing_gen_if #(.CNT_W(CW)) vif ();

    dvi_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0),
        .SETTLE_CYCLES(SETTLE), .CNT_W(CW)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .vid    (vif)
    );

    always #20 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Edges from the Cfg_done sample edge until Req is seen high
    task automatic measure_latency(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!vif.Req && n < 3000);
    endtask

    int   lat, k, q, h, v, cnt;
    int   de_err, pix_err, req_err, ls_cnt0, fs_cnt, vs_low0, vs_fall, hs_fall;
    int   hs_low0, de_line0, de_rise2, fs2, fs2_px, fs2_py;
    logic prev_req, prev_de, exp_de, found;

    initial begin
        Reset_n = 1'b0;
        vif.Cfg_done = 1'b1;
        repeat (5) tick();
        check("rst_hsync",   vif.Hsync, 1);
        check("rst_vsync",   vif.Vsync, 1);
        check("rst_de",      vif.De, 0);
        check("rst_req",     vif.Req, 0);
        check("rst_running", vif.Running, 0);
        check("rst_fs",      vif.Frame_start, 0);
        check("rst_pix_x",   vif.Pix_x, 0);
        check("rst_pix_y",   vif.Pix_y, 0);

        // Start-up latency from reset release with Cfg_done already high
        @(negedge Clk);
        Reset_n = 1'b1;
        measure_latency(lat);
        check("start_latency", lat, SETTLE + 1);
        check("start_running", vif.Running, 1);
        check("start_de_low",  vif.De, 0);
        prev_req = vif.Req;
        tick();
        check("first_de", vif.De, 1);
        check("first_fs", vif.Frame_start, 1);
        check("first_px", vif.Pix_x, 0);
        check("first_py", vif.Pix_y, 0);

        // Two frames observed; position k is the raster index the outputs reflect
        de_err = 0; pix_err = 0; req_err = 0; ls_cnt0 = 0; fs_cnt = 0; vs_low0 = 0;
        vs_fall = -1; hs_fall = -1; hs_low0 = 0; de_line0 = 0; de_rise2 = -1;
        fs2 = -1; fs2_px = -1; fs2_py = -1; prev_de = 1'b0;
        for (k = 0; k < 2 * FRAME; k++) begin
            if (k > 0) tick();
            q = k % FRAME;
            h = q % HT;
            v = q / HT;
            exp_de = (h < HA) && (v < VA);
            if (vif.De !== exp_de) de_err++;
            if (vif.De && (vif.Pix_x != CW'(h) || vif.Pix_y != CW'(v))) pix_err++;
            if (prev_req !== vif.De) req_err++;
            prev_req = vif.Req;
            if (k < FRAME) begin
                if (vif.Line_start) ls_cnt0++;
                if (!vif.Vsync) begin
                    vs_low0++;
                    if (vs_fall < 0) vs_fall = k;
                end
            end
            if (k < HT) begin
                if (vif.De) de_line0++;
                if (!vif.Hsync) begin
                    hs_low0++;
                    if (hs_fall < 0) hs_fall = k;
                end
            end
            if (k > 0 && vif.De && !prev_de && de_rise2 < 0) de_rise2 = k;
            if (vif.Frame_start) begin
                fs_cnt++;
                if (k > 0 && fs2 < 0) begin
                    fs2 = k;
                    fs2_px = int'(vif.Pix_x);
                    fs2_py = int'(vif.Pix_y);
                end
            end
            prev_de = vif.De;
        end
        check("line_de_len",    de_line0, HA);
        check("hsync_fall",     hs_fall, HA + HFP);
        check("hsync_len",      hs_low0, HS);
        check("de_period",      de_rise2, HT);
        check("line_starts",    ls_cnt0, VA);
        check("vsync_fall",     vs_fall, (VA + VFP) * HT);
        check("vsync_len",      vs_low0, VS * HT);
        check("frame_period",   fs2, FRAME);
        check("fs2_px",         fs2_px, 0);
        check("fs2_py",         fs2_py, 0);
        check("frame_starts",   fs_cnt, 2);
        check("de_pattern_err", de_err, 0);
        check("pix_err",        pix_err, 0);
        check("req_lead_err",   req_err, 0);

        // Config loss mid-line
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            tick();
            if (vif.De && vif.Pix_x == CW'(20) && vif.Pix_y == CW'(7)) found = 1'b1;
        end
        check("loss_point_found", found, 1);
        vif.Cfg_done = 1'b0;
        tick();
        check("loss_req_e1",     vif.Req, 0);
        check("loss_running_e1", vif.Running, 0);
        tick();
        check("loss_de",      vif.De, 0);
        check("loss_req",     vif.Req, 0);
        check("loss_running", vif.Running, 0);
        check("loss_hsync",   vif.Hsync, 1);
        check("loss_vsync",   vif.Vsync, 1);
        check("loss_pix_x",   vif.Pix_x, 0);
        check("loss_pix_y",   vif.Pix_y, 0);
        repeat (5) tick();
        vif.Cfg_done = 1'b1;
        measure_latency(lat);
        check("restart_latency", lat, SETTLE + 1);
        tick();
        check("restart_fs", vif.Frame_start, 1);
        check("restart_px", vif.Pix_x, 0);
        check("restart_py", vif.Pix_y, 0);

        // Aborted settles: one-cycle glitch, then a 500-cycle pulse
        vif.Cfg_done = 1'b0;
        repeat (3) tick();
        vif.Cfg_done = 1'b1;
        tick();
        vif.Cfg_done = 1'b0;
        cnt = 0;
        for (int i = 0; i < 1200; i++) begin
            tick();
            if (vif.Req || vif.De || vif.Running) cnt++;
        end
        check("abort1_activity", cnt, 0);
        vif.Cfg_done = 1'b1;
        cnt = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (vif.Req || vif.De || vif.Running) cnt++;
        end
        vif.Cfg_done = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            tick();
            if (vif.Req || vif.De || vif.Running) cnt++;
        end
        check("abort500_activity", cnt, 0);
        vif.Cfg_done = 1'b1;
        measure_latency(lat);
        check("post_abort_latency", lat, SETTLE + 1);

        // Asynchronous reset while De is high
        found = 1'b0;
        for (int i = 0; i < FRAME && !found; i++) begin
            tick();
            if (vif.De) found = 1'b1;
        end
        check("areset_de_found", found, 1);
        #5;
        Reset_n = 1'b0;
        #1;
        check("areset_de",      vif.De, 0);
        check("areset_req",     vif.Req, 0);
        check("areset_running", vif.Running, 0);
        check("areset_hsync",   vif.Hsync, 1);
        check("areset_pix_x",   vif.Pix_x, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dvi_timing_gen.md
# dvi_timing_gen

Raster timing generator for the DVI output path. It sits directly downstream of the DVI I2C configuration block and starts only after that block reports the transmitter configured (`Done`). After a settle interval it produces continuous 640x480@60 sync, data-enable and pixel-coordinate signals at the 25 MHz pixel clock. It also issues a one-cycle-early pixel request to the frame source.

## Interface
- `H_ACTIVE`, 640: active pixels per line
- `H_FP`, 16: horizontal front porch, in cycles
- `H_SYNC`, 96: hsync width, in cycles
- `H_BP`, 48: horizontal back porch, in cycles
- `V_ACTIVE`, 480: active lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `HS_POL`, 0: hsync active level (0 = active-low)
- `VS_POL`, 0: vsync active level (0 = active-low)
- `SETTLE_CYCLES`, 1024: delay from `Cfg_done` rising to the first timing cycle
- `CNT_W`, 10: width of the counters and coordinate outputs
- `Clk` in 1: pixel clock, 25 MHz
- `Reset_n` in 1: asynchronous, active-low reset
- `Cfg_done` in 1: configuration complete; driven by the I2C config block `Done`
- `Hsync` out 1: horizontal sync, polarity set by `HS_POL`
- `Vsync` out 1: vertical sync, polarity set by `VS_POL`
- `De` out 1: data enable, high during active pixels
- `Req` out 1: pixel request, asserted exactly one cycle before each `De` cycle
- `Pix_x` out `CNT_W`: column of the current `De` pixel
- `Pix_y` out `CNT_W`: row of the current `De` pixel
- `Line_start` out 1: one-cycle pulse on the first `De` cycle of each active line
- `Frame_start` out 1: one-cycle pulse on the first `De` cycle of each frame, (x,y) = (0,0)
- `Running` out 1: high while in state RUN

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- States:
  - WAIT_CFG (reset state): counters held at 0. `Cfg_done`=1 moves to SETTLE.
  - SETTLE: counter `s_cnt` counts 0..SETTLE_CYCLES-1, then moves to RUN with `h_cnt`=`v_cnt`=0. `Cfg_done`=0 returns to WAIT_CFG.
  - RUN: timing runs continuously. `Cfg_done`=0 returns to WAIT_CFG.
- `h_cnt` counts 0..H_TOTAL-1 and wraps to 0. `v_cnt` increments only when `h_cnt` wraps, counts 0..V_TOTAL-1, and wraps to 0.
- Region order, for both axes: active, front porch, sync, back porch.
  - Hsync active when H_ACTIVE+H_FP <= `h_cnt` < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - Vsync active when V_ACTIVE+V_FP <= `v_cnt` < V_ACTIVE+V_FP+V_SYNC, i.e. lines 490..491. Vsync is decoded from `v_cnt` only, so its edges align with the `h_cnt`=0 boundary.
  - Active pixel when `h_cnt` < H_ACTIVE and `v_cnt` < V_ACTIVE.
- Outputs are registered decodes of the counters, with a fixed 1-cycle lag:
  - `De`, `Hsync`, `Vsync`, `Pix_x`, `Pix_y`, `Line_start` and `Frame_start` at cycle n+1 reflect the counters at cycle n.
  - `Req` is decoded from the counter state one step ahead, so `Req` leads `De` by exactly one cycle, including the last pixel of line 479. `Req` is never high while `De` is low in the following cycle.
- `Pix_x`/`Pix_y` are valid only when `De`=1. They hold their last values when `De`=0.
- Outside RUN: `De`, `Req`, `Line_start`, `Frame_start` and `Running` are 0, both syncs are at their inactive level, and `Pix_x`/`Pix_y` are 0.

## Timing
- Reset values: `De`=0, `Req`=0, `Line_start`=0, `Frame_start`=0, `Running`=0, `Pix_x`=0, `Pix_y`=0, `Hsync`=~HS_POL, `Vsync`=~VS_POL. State is WAIT_CFG and all counters are 0.
- Start-up latency: `Cfg_done` rises in cycle c. SETTLE is entered in cycle c+1. RUN is entered in cycle c+1+SETTLE_CYCLES. `Running` and the first `Req` are high in that same cycle. The first `De` and `Frame_start` follow one cycle later.
- Steady state: the `De` high period per line is 640 cycles. The frame period is H_TOTAL*V_TOTAL = 420000 cycles. `Frame_start` recurs every 420000 cycles exactly.
- Loss of `Cfg_done`: `Cfg_done` falling in any state returns the block to WAIT_CFG on the next edge. All outputs reach their idle values one cycle later, and no partial `De` cycle occurs after that. A later rise of `Cfg_done` restarts the full SETTLE interval.
- `Cfg_done` glitching high for a single cycle: SETTLE is entered and immediately aborted. No `Req` or `De` is produced.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronous).

## Test plan
- Reset: hold `Reset_n`=0 with `Cfg_done`=1 → `Hsync`=1, `Vsync`=1, `De`=0, `Running`=0. Release reset → first `Req` exactly 1025 cycles later; `De` and `Frame_start` one cycle after that.
- Single line in RUN:
  - `De` is high 640 consecutive cycles with `Pix_x` stepping 0..639.
  - `Hsync` goes low 656 cycles after `De` rises and stays low 96 cycles.
  - `De` rises again 800 cycles after its previous rise.
- Full frame:
  - 480 `Line_start` pulses per frame.
  - `Vsync` low for 1600 cycles, starting 490*800 cycles after `Frame_start`.
  - Next `Frame_start` occurs 420000 cycles later, with `Pix_y`=0.
- Request lead: on every cycle of 2 frames, `Req`(n) == `De`(n+1), including the last pixel of line 479 and the pixel (0,0) after frame wrap.
- Config loss: drop `Cfg_done` at `Pix_x`=300, `Pix_y`=200 → `De`, `Req` and `Running` are 0 within 2 edges and the syncs return to 1. Re-raise `Cfg_done` → a new full 1024-cycle settle, then `Frame_start` at (0,0).
- Abort: pulse `Cfg_done` high for 1 cycle and also for 500 cycles → `Req` and `De` never assert, and the block returns to WAIT_CFG.
